// File: rtl/tpu_bus_pkg.sv
// Bus map, command codes, status bits and sequencer state encoding shared by the
// TPU job sequencer and anything else that talks to the TPU bus-slave wrapper.
package tpu_bus_pkg;

  localparam logic [1:0] SPACE_CONTROL = 2'b00;
  localparam logic [1:0] SPACE_INPUT   = 2'b01;
  localparam logic [1:0] SPACE_WEIGHT  = 2'b10;
  localparam logic [1:0] SPACE_OUTPUT  = 2'b11;

  localparam logic [3:0] CMD_RESET      = 4'hF;
  localparam logic [3:0] CMD_FILL_FIFO  = 4'h1;
  localparam logic [3:0] CMD_DRAIN_FIFO = 4'h2;
  localparam logic [3:0] CMD_MULTIPLY   = 4'h3;

  localparam int STAT_FILL_DONE   = 0;
  localparam int STAT_DRAIN_DONE  = 1;
  localparam int STAT_OUTPUT_DONE = 2;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_RST    = 4'd1;
  localparam logic [3:0] ST_LD_W   = 4'd2;
  localparam logic [3:0] ST_LD_I   = 4'd3;
  localparam logic [3:0] ST_FILL   = 4'd4;
  localparam logic [3:0] ST_POLL_F = 4'd5;
  localparam logic [3:0] ST_DRAIN  = 4'd6;
  localparam logic [3:0] ST_POLL_D = 4'd7;
  localparam logic [3:0] ST_MULT   = 4'd8;
  localparam logic [3:0] ST_POLL_O = 4'd9;
  localparam logic [3:0] ST_RD_O   = 4'd10;
  localparam logic [3:0] ST_DONE   = 4'd11;
  localparam logic [3:0] ST_ERR    = 4'd12;

  // Rows live in an 8-bit space, so base + offset wraps modulo 256.
  function automatic logic [9:0] row_addr(input logic [1:0] space, input logic [7:0] base,
                                          input logic [7:0] off);
    logic [7:0] row;
    row = base + off;
    return {space, row};
  endfunction

endpackage

// File: rtl/tpu_seq_out_buf.sv
// One-entry result holding register: captures a completed output read and
// presents it on the dst valid/ready stream until the sink takes it.
module tpu_seq_out_buf #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  dst_ready,
  output logic                  dst_valid,
  output logic [DATA_WIDTH-1:0] dst_data,
  output logic                  free
);

  // Free when empty or emptying this cycle, so a load never overwrites a live word.
  assign free = !dst_valid || dst_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dst_valid <= 1'b0;
      dst_data  <= '0;
    end else if (load) begin
      dst_valid <= 1'b1;
      dst_data  <= load_data;
    end else if (dst_ready) begin
      dst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tpu_job_sequencer.sv
// Avalon-MM master that runs one full matrix-multiply job on the TPU slave:
// reset, load weights/inputs, fill, drain, multiply, poll, then stream results out.
module tpu_job_sequencer
  import tpu_bus_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int WIDTH_HEIGHT = 16,
  parameter int POLL_LIMIT   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              weight_base,
  input  logic [7:0]              input_base,
  input  logic [7:0]              output_base,
  input  logic [7:0]              num_rows,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [DATA_WIDTH-1:0]   src_data,
  output logic                    dst_valid,
  input  logic                    dst_ready,
  output logic [DATA_WIDTH-1:0]   dst_data,
  output logic [9:0]              m_address,
  output logic                    m_read,
  output logic                    m_write,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  output logic [DATA_WIDTH/8-1:0] m_byteenable,
  input  logic [DATA_WIDTH-1:0]   m_readdata,
  input  logic                    m_waitrequest,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  logic [3:0]    state;
  logic [7:0]    w_base, i_base, o_base, rows;
  logic [8:0]    idx;
  logic [1:0]    gap;
  logic [PW-1:0] polls;
  logic          poll_rd, rd_hold;
  logic          in_load, out_rd, buf_free, buf_load, flag;

  always_comb begin
    in_load = 1'b0;
    if (state == ST_LD_W)      in_load = 1'b1;
    else if (state == ST_LD_I) in_load = idx < {1'b0, rows};
  end

  always_comb begin
    case (state)
      ST_POLL_F: flag = m_readdata[STAT_FILL_DONE];
      ST_POLL_D: flag = m_readdata[STAT_DRAIN_DONE];
      default:   flag = m_readdata[STAT_OUTPUT_DONE];
    endcase
  end

  assign src_ready    = in_load && (!m_write || !m_waitrequest);
  // A stalled output read stays asserted even if the sink stops draining meanwhile.
  assign out_rd       = (state == ST_RD_O) && (rd_hold || (idx < {1'b0, rows} && buf_free));
  assign m_read       = poll_rd || out_rd;
  assign buf_load     = out_rd && !m_waitrequest;
  assign m_byteenable = '1;
  assign busy         = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);
  assign done         = (state == ST_DONE);

  tpu_seq_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .load_data (m_readdata),
    .dst_ready (dst_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .free      (buf_free)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      w_base      <= '0;
      i_base      <= '0;
      o_base      <= '0;
      rows        <= '0;
      idx         <= '0;
      gap         <= '0;
      polls       <= '0;
      poll_rd     <= 1'b0;
      rd_hold     <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
      error       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          w_base      <= weight_base;
          i_base      <= input_base;
          o_base      <= output_base;
          rows        <= (num_rows == 8'd0) ? 8'd1 : num_rows;
          error       <= 1'b0;
          m_write     <= 1'b1;
          m_address   <= '0;
          m_writedata <= DATA_WIDTH'(CMD_RESET);
          state       <= ST_RST;
        end
        // Command states: one control write, then a short idle gap.
        ST_RST, ST_FILL, ST_DRAIN, ST_MULT: begin
          if (m_write) begin
            if (!m_waitrequest) begin
              m_write <= 1'b0;
              gap     <= (state == ST_RST) ? 2'd2 : 2'd1;
            end
          end else if (gap != 2'd1) begin
            gap <= gap - 2'd1;
          end else if (state == ST_RST) begin
            idx   <= '0;
            state <= ST_LD_W;
          end else begin
            poll_rd <= 1'b1;
            polls   <= '0;
            state   <= (state == ST_FILL) ? ST_POLL_F : (state == ST_DRAIN) ? ST_POLL_D : ST_POLL_O;
          end
        end
        // Accepted source words become bus writes one cycle later.
        ST_LD_W, ST_LD_I: begin
          if (m_write && !m_waitrequest) m_write <= 1'b0;
          if (src_valid && src_ready) begin
            m_write     <= 1'b1;
            m_writedata <= src_data;
            m_address   <= (state == ST_LD_W) ? row_addr(SPACE_WEIGHT, w_base, idx[7:0])
                                              : row_addr(SPACE_INPUT, i_base, idx[7:0]);
            if (state == ST_LD_W && idx == 9'(WIDTH_HEIGHT - 1)) begin
              idx   <= '0;
              state <= ST_LD_I;
            end else begin
              idx <= idx + 9'd1;
            end
          end else if (state == ST_LD_I && !in_load && (!m_write || !m_waitrequest)) begin
            m_write     <= 1'b1;
            m_address   <= '0;
            m_writedata <= DATA_WIDTH'({w_base, CMD_FILL_FIFO});
            state       <= ST_FILL;
          end
        end
        ST_POLL_F, ST_POLL_D, ST_POLL_O: if (!m_waitrequest) begin
          polls <= polls + PW'(1);
          if (flag) begin
            poll_rd <= 1'b0;
            case (state)
              ST_POLL_F: begin
                m_write     <= 1'b1;
                m_writedata <= DATA_WIDTH'(CMD_DRAIN_FIFO);
                state       <= ST_DRAIN;
              end
              ST_POLL_D: begin
                m_write     <= 1'b1;
                m_writedata <= DATA_WIDTH'({o_base, i_base, CMD_MULTIPLY});
                state       <= ST_MULT;
              end
              default: begin
                idx       <= '0;
                m_address <= row_addr(SPACE_OUTPUT, o_base, 8'd0);
                state     <= ST_RD_O;
              end
            endcase
          end else if (polls == PW'(POLL_LIMIT - 1)) begin
            poll_rd <= 1'b0;
            state   <= ST_ERR;
          end
        end
        ST_RD_O: begin
          rd_hold <= out_rd && m_waitrequest;
          if (buf_load) begin
            idx       <= idx + 9'd1;
            m_address <= row_addr(SPACE_OUTPUT, o_base, idx[7:0] + 8'd1);
          end
          if (idx == {1'b0, rows} && buf_free) begin
            m_address <= '0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR: begin
          error <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Randomized job-level bench: a TPU slave model answers the bus, and each job's
// bus traffic and result stream are compared against lists built from the job parameters.
module tb_tpu_job_sequencer;

  localparam int DW = 64;
  localparam int WH = 16;
  localparam int PL = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    weight_base = '0, input_base = '0, output_base = '0, num_rows = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [DW-1:0] src_data = '0;
  logic          dst_valid;
  logic          dst_ready = 1'b1;
  logic [DW-1:0] dst_data;
  logic [9:0]    m_address;
  logic          m_read, m_write;
  logic [DW-1:0] m_writedata;
  logic [DW/8-1:0] m_byteenable;
  logic [DW-1:0] m_readdata;
  logic          m_waitrequest = 1'b0;
  logic          busy, done, error;

  always #5 clk = ~clk;

  tpu_job_sequencer #(.DATA_WIDTH(DW), .WIDTH_HEIGHT(WH), .POLL_LIMIT(PL)) dut (
    .clk(clk), .reset(reset), .start(start),
    .weight_base(weight_base), .input_base(input_base), .output_base(output_base),
    .num_rows(num_rows),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .busy(busy), .done(done), .error(error)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave model state
  logic [2:0]  flags = '0;
  int          tmr[3];
  logic [63:0] out_mem[256];
  bit          never_out = 0;

  always_comb begin
    m_readdata = '0;
    if (m_address[9:8] == 2'b00)      m_readdata = {61'd0, flags};
    else if (m_address[9:8] == 2'b11) m_readdata = out_mem[m_address[7:0]];
  end

  // Observation and stimulus state
  logic [9:0]  wr_a[$];
  logic [63:0] wr_d[$];
  logic [9:0]  rd_a[$];
  logic [63:0] dst_q[$];
  logic [63:0] src_q[$];
  int          src_pos, polls_o, done_cnt, overrun, cyc;
  bit          mult_seen, toggle, bp_en, bp_started, wait_en, wait_started;
  int          bp_left, wait_left;
  logic [9:0]  hold_a;
  logic [63:0] hold_d;
  logic [7:0]  cur_wb;

  task automatic apply_cmd(input logic [3:0] c);
    case (c)
      4'hF: begin flags = '0; tmr[0] = 0; tmr[1] = 0; tmr[2] = 0; end
      4'h1: tmr[0] = 5;
      4'h2: tmr[1] = 5;
      4'h3: begin mult_seen = 1; if (!never_out) tmr[2] = 5; end
      default: ;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      if (tmr[i] > 0) begin
        tmr[i]--;
        if (tmr[i] == 0) flags[i] = 1'b1;
      end
    if (m_write && !m_waitrequest) begin
      wr_a.push_back(m_address);
      wr_d.push_back(m_writedata);
      if (m_address == 10'h000) apply_cmd(m_writedata[3:0]);
    end
    if (m_read && !m_waitrequest) begin
      if (m_address[9:8] == 2'b00) begin
        if (mult_seen) polls_o++;
      end else rd_a.push_back(m_address);
    end
    if (m_read && m_address[9:8] == 2'b11 && dst_valid && !dst_ready) overrun++;
    if (dst_valid && dst_ready) dst_q.push_back(dst_data);
    if (done) done_cnt++;
    if (src_valid && src_ready) src_pos++;
    if (m_waitrequest) begin
      chk("stall_addr", m_address, hold_a);
      chk("stall_data", m_writedata, hold_d);
      chk("stall_src_ready", src_ready, 0);
    end
    cyc++;
    @(posedge clk); #1;
    start = 1'b0;
    src_valid = (src_pos < src_q.size()) && (!toggle || cyc[0]);
    src_data  = (src_pos < src_q.size()) ? src_q[src_pos] : '0;
    if (bp_en && !bp_started && dst_q.size() >= 2) begin
      bp_started = 1;
      bp_left = 10;
    end
    dst_ready = (bp_left == 0);
    if (bp_left > 0) bp_left--;
    if (wait_en && !wait_started && m_write && m_address == {2'b10, cur_wb + 8'd5}) begin
      wait_started = 1;
      wait_left = 3;
      hold_a = m_address;
      hold_d = m_writedata;
    end
    m_waitrequest = (wait_left > 0);
    if (wait_left > 0) wait_left--;
  endtask

  task automatic run_job(input logic [7:0] wb, ib, ob, nr, input bit tog, bp, wt, nvo, abort);
    logic [7:0]  rows_eff, r;
    logic [9:0]  ea[$];
    logic [63:0] ed[$];
    logic [63:0] w;
    int n;
    bit fin;
    rows_eff = (nr == 8'd0) ? 8'd1 : nr;
    src_q.delete(); wr_a.delete(); wr_d.delete(); rd_a.delete(); dst_q.delete();
    for (int i = 0; i < 256; i++) out_mem[i] = {$urandom, $urandom};
    toggle = tog; bp_en = bp; bp_started = 0; bp_left = 0;
    wait_en = wt; wait_started = 0; wait_left = 0; cur_wb = wb;
    never_out = nvo; mult_seen = 0; polls_o = 0; done_cnt = 0; overrun = 0; src_pos = 0;
    ea.push_back(10'h000); ed.push_back(64'hF);
    for (int i = 0; i < WH; i++) begin
      w = {$urandom, $urandom};
      src_q.push_back(w);
      r = wb + 8'(i);
      ea.push_back({2'b10, r}); ed.push_back(w);
    end
    for (int j = 0; j < int'(rows_eff); j++) begin
      w = {$urandom, $urandom};
      src_q.push_back(w);
      r = ib + 8'(j);
      ea.push_back({2'b01, r}); ed.push_back(w);
    end
    ea.push_back(10'h000); ed.push_back((64'(wb) << 4) | 64'h1);
    ea.push_back(10'h000); ed.push_back(64'h2);
    ea.push_back(10'h000); ed.push_back((64'(ob) << 12) | (64'(ib) << 4) | 64'h3);

    weight_base = wb; input_base = ib; output_base = ob; num_rows = nr; start = 1'b1;
    step();
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
    n = 0; fin = 0;
    while (!fin && n < 3000) begin
      step();
      n++;
      if (done_cnt > 0 || error) fin = 1;
      if (abort && wr_a.size() > 0 && wr_a[wr_a.size()-1][9:8] == 2'b01) begin
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_m_write", m_write, 0);
        chk("abort_busy", busy, 0);
        chk("abort_src_ready", src_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        src_q.delete(); src_pos = 0; src_valid = 1'b0;
        return;
      end
    end
    chk("job_ended", fin, 1);
    repeat (4) step();
    chk("n_writes", wr_a.size(), ea.size());
    for (int i = 0; i < ea.size(); i++)
      if (i < wr_a.size()) begin
        chk("wr_addr", wr_a[i], ea[i]);
        chk("wr_data", wr_d[i], ed[i]);
      end
    if (!nvo) begin
      chk("n_out_reads", rd_a.size(), rows_eff);
      chk("n_dst_words", dst_q.size(), rows_eff);
      for (int k = 0; k < int'(rows_eff); k++) begin
        r = ob + 8'(k);
        if (k < rd_a.size())  chk("out_read_addr", rd_a[k], {2'b11, r});
        if (k < dst_q.size()) chk("dst_data", dst_q[k], out_mem[r]);
      end
      chk("done_pulses", done_cnt, 1);
      chk("error_clear", error, 0);
    end else begin
      chk("poll_o_reads", polls_o, PL);
      chk("error_set", error, 1);
      chk("no_done", done_cnt, 0);
      chk("no_out_reads", rd_a.size(), 0);
    end
    if (wt) chk("stall_injected", wait_started, 1);
    chk("read_while_full", overrun, 0);
    chk("idle_after_job", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tmr[0] = 0; tmr[1] = 0; tmr[2] = 0;
    for (int i = 0; i < 256; i++) out_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_read", m_read, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_dst_valid", dst_valid, 0);
    chk("rst_m_address", m_address, 0);
    chk("byteenable", m_byteenable, 8'hFF);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) step();

    run_job(8'h10, 8'h20, 8'h40, 8'd4, 0, 0, 0, 0, 0);
    run_job(8'hF8, 8'hFE, 8'hFE, 8'd4, 0, 0, 0, 0, 0);
    run_job(8'h00, 8'h30, 8'h80, 8'd6, 1, 1, 0, 0, 0);
    run_job(8'h50, 8'h60, 8'h70, 8'd3, 0, 0, 1, 0, 0);
    run_job(8'h10, 8'h20, 8'h40, 8'd4, 0, 0, 0, 1, 0);
    run_job(8'h11, 8'h22, 8'h33, 8'd2, 0, 0, 0, 0, 0);
    run_job(8'h10, 8'h20, 8'h40, 8'd5, 0, 0, 0, 0, 1);
    run_job(8'h10, 8'h20, 8'h40, 8'd5, 0, 0, 0, 0, 0);
    run_job(8'hA0, 8'hFF, 8'h01, 8'd0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 4; t++)
      run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(1, 10)),
              1'($urandom), 1'($urandom), 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
